// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder: 4-bit lookahead groups resolved by a second-level unit.
// Build option: define CLA_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
    end
    if (GROUP != 4) begin : g_bad_group
        $error("cla_pipe_adder: GROUP is fixed at 4");
    end

    // Carry into group k+1 as a flat sum of products over PG/GG and the carry-in,
    // so no group carry depends on another group carry.
    function automatic logic group_carry(
        input logic [NG-1:0] pg,
        input logic [NG-1:0] gg,
        input logic          c0,
        input int            k
    );
        logic acc;
        logic prop;
        acc  = 1'b0;
        prop = 1'b1;
        for (int j = NG - 1; j >= 0; j--) begin
            if (j <= k) begin
                acc  = acc | (prop & gg[j]);
                prop = prop & pg[j];
            end
        end
        return acc | (prop & c0);
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid_q;
    logic out_valid_q;
    logic adv1;
    logic adv2;
    logic accept;

    assign adv2     = !out_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1 & !rst;
    assign accept   = in_valid & in_ready;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    logic [WIDTH-1:0]      p_d;
    logic [NG-1:0][2:0]    g_d;
    logic [NG-1:0]         pg_d;
    logic [NG-1:0]         gg_d;
    logic [WIDTH-1:0]      g_full;

    assign p_d    = a ^ b_eff;
    assign g_full = a & b_eff;

    for (genvar k = 0; k < NG; k++) begin : g_s1_grp
        logic [3:0] gp;
        logic [3:0] gg4;
        assign gp      = p_d[4*k +: 4];
        assign gg4     = g_full[4*k +: 4];
        assign g_d[k]  = gg4[2:0];
        assign pg_d[k] = &gp;
        assign gg_d[k] = gg4[3]
                       | (gp[3] & gg4[2])
                       | (gp[3] & gp[2] & gg4[1])
                       | (gp[3] & gp[2] & gp[1] & gg4[0]);
    end

    logic [WIDTH-1:0]   p_q;
    logic [NG-1:0][2:0] g_q;
    logic [NG-1:0]      pg_q;
    logic [NG-1:0]      gg_q;
    logic               c0_q;
    logic               a_msb_q;
    logic               b_msb_q;

    // ---------------- stage 2 ----------------
    logic [NG:0]        grp_c;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d;
    logic               ovf_d;

    assign grp_c[0] = c0_q;

    for (genvar k = 0; k < NG; k++) begin : g_s2_grp
        logic [3:0] gp;
        logic [2:0] gg3;
        logic       ck;
        assign gp  = p_q[4*k +: 4];
        assign gg3 = g_q[k];
        assign ck  = grp_c[k];

        assign grp_c[k+1] = group_carry(pg_q, gg_q, c0_q, k);

        assign c[4*k]     = ck;
        assign c[4*k + 1] = gg3[0] | (gp[0] & ck);
        assign c[4*k + 2] = gg3[1] | (gp[1] & gg3[0]) | (gp[1] & gp[0] & ck);
        assign c[4*k + 3] = gg3[2] | (gp[2] & gg3[1]) | (gp[2] & gp[1] & gg3[0])
                          | (gp[2] & gp[1] & gp[0] & ck);
    end

    assign sum_d  = p_q ^ c;
    assign cout_d = grp_c[NG];
    assign ovf_d  = (a_msb_q == b_msb_q) & (sum_d[WIDTH-1] != a_msb_q);

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            pg_q        <= '0;
            gg_q        <= '0;
            c0_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= accept;
                if (accept) begin
                    p_q     <= p_d;
                    g_q     <= g_d;
                    pg_q    <= pg_d;
                    gg_q    <= gg_d;
                    c0_q    <= cin_eff;
                    a_msb_q <= a[WIDTH-1];
                    b_msb_q <= b_eff[WIDTH-1];
                end
            end
            // Result registers only move on a real transfer, so they hold through stalls.
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder at WIDTH=16.
// Subtract vectors run only when CLA_SUB_EN is defined.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed vectors: a + b + cin (mod 2^16), carry out, signed overflow.
    logic [15:0] va  [8] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h8000, 16'h0F0F, 16'h4000, 16'hABCD, 16'h0000};
    logic [15:0] vb  [8] = '{16'h4321, 16'hFFFF, 16'h0F01, 16'hFFFF, 16'hF0F0, 16'h4000, 16'h1111, 16'h0000};
    logic        vc  [8] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
    logic [15:0] vs  [8] = '{16'h5555, 16'hFFFF, 16'h1000, 16'h7FFF, 16'h0000, 16'h8000, 16'hBCDE, 16'h0001};
    logic        vco [8] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
    logic        vov [8] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};

    // Backpressure script: operand index driven, out_ready, expected in_ready, expected output index.
    int bp_drv [10] = '{0, 1, 2, 2, 2, 2, 3, -1, -1, -1};
    int bp_ord [10] = '{0, 0, 0, 0, 0, 1, 1,  1,  1,  1};
    int bp_eir [10] = '{1, 1, 0, 0, 0, 1, 1,  1,  1,  1};
    int bp_out [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input int idx);
        if (idx < 0) begin
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            a        = va[idx];
            b        = vb[idx];
            cin      = vc[idx];
        end
    endtask

    task automatic chk_out(input string tag, input int idx);
        if (idx < 0) begin
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        end else begin
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_sum"},   {16'd0, sum},       {16'd0, vs[idx]});
            chk({tag, "_cout"},  {31'd0, cout},      {31'd0, vco[idx]});
            chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, vov[idx]});
        end
    endtask

    task automatic single_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        step();
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        smp();
        step();
        in_valid = 1'b0;
        smp();
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        step();
        smp();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"},   {16'd0, sum},       {16'd0, es});
        chk({tag, "_cout"},  {31'd0, cout},      {31'd0, ec});
        chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;

        // Reset state
        step();
        smp();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_cout",      {31'd0, cout},      32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        step();
        rst = 1'b0;
        smp();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Carry through all four groups, and signed overflow corners
        single_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        single_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        single_op("ovf_neg",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-to-back throughput with out_ready held high
        for (int n = 0; n < 10; n++) begin
            step();
            drive((n < 8) ? n : -1);
            smp();
            chk($sformatf("tput%0d_in_ready", n), {31'd0, in_ready}, 32'd1);
            chk_out($sformatf("tput%0d", n), (n >= 2) ? n - 2 : -1);
        end

        // Backpressure: 5 stalled cycles, then drain
        for (int n = 0; n < 10; n++) begin
            step();
            drive(bp_drv[n]);
            out_ready = bp_ord[n][0];
            smp();
            chk($sformatf("bp%0d_in_ready", n), {31'd0, in_ready}, bp_eir[n]);
            chk_out($sformatf("bp%0d", n), bp_out[n]);
        end

        // Reset with both stages full
        step();
        drive(3);
        out_ready = 1'b0;
        smp();
        chk_out("rf0", -1);
        step();
        drive(5);
        smp();
        chk_out("rf1", -1);
        step();
        drive(-1);
        rst = 1'b1;
        smp();
        chk_out("rf2_full", 3);
        chk("rf2_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(6);
        smp();
        chk("rf3_valid",    {31'd0, out_valid}, 32'd0);
        chk("rf3_sum",      {16'd0, sum},       32'd0);
        chk("rf3_cout",     {31'd0, cout},      32'd0);
        chk("rf3_ovf",      {31'd0, ovf},       32'd0);
        chk("rf3_in_ready", {31'd0, in_ready},  32'd1);
        step();
        drive(-1);
        smp();
        chk_out("rf4", -1);
        step();
        smp();
        chk_out("rf5", 6);
        step();
        smp();
        chk_out("rf6", -1);

`ifdef CLA_SUB_EN
        sub = 1'b1;
        single_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        single_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        sub = 1'b0;
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
